// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Sequences ADC and per-channel DAC resets from internal, external or SATA
// triggers. Adds watchdog supervision, ramp-down-before-reset handshaking per
// DAC channel and a programmable ADC start delay after the DACs are released.
//
// Optional feature macro: RESET_SEQ_WATCHDOG_EN
//   defined   -> watchdog counter, watchdog fault and reset_sts[6] exist
//   undefined -> no watchdog logic; cfg[1] is ignored and reset_sts[6] = 0
//
// Ports
//   clk                 system clock
//   peripheral_areset   asynchronous active-high reset
//   cfg[7:0]            0 trigger mode, 1 watchdog en, 2 SATA propagate,
//                       3 instant-reset en, 4 external trigger select,
//                       5 internal trigger en, 6 keep-alive run
//   adc_delay           cycles from RUN entry to ADC release
//   is_master           board is SATA master (ignores incoming SATA trigger)
//   counter_trigger     internal trigger source
//   ext_trigger         asynchronous DIO trigger
//   sata_trigger        asynchronous SATA trigger
//   watchdog            asynchronous watchdog toggle
//   instant_reset       asynchronous emergency stop
//   ramp_enable         channel uses ramp-down before reset
//   ramp_done           channel ramp-down finished (level)
//   adc_aresetn         ADC writer reset (active low)
//   dac_aresetn         per-channel synthesizer reset (active low)
//   start_ramp_down     per-channel ramp-down request
//   keep_alive_aresetn  keep-alive block reset
//   alive_signal        heartbeat
//   reset_ack           shutdown caused by a fault is in progress
//   master_trigger      trigger driven to slave boards
//   sata_out            propagated trigger
//   reset_sts           status word
//
// State | meaning
// IDLE  | waiting for trigger, all resets asserted
// RUN   | DACs released, ADC released after delay, supervising faults
// RAMP  | ramping channels winding down, others already in reset
// HALT  | all in reset, waiting for trigger to drop before re-arming
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_CH              = 2,
    parameter int ALIVE_LOW_CYCLES    = 12500000,
    parameter int ALIVE_HIGH_CYCLES   = 1250000,
    parameter int WD_TIMEOUT_CYCLES   = 1250000,
    parameter int RAMP_TIMEOUT_CYCLES = 125000000,
    parameter int ADC_DELAY_W         = 16
) (
    input  logic                   clk,
    input  logic                   peripheral_areset,
    input  logic [7:0]             cfg,
    input  logic [ADC_DELAY_W-1:0] adc_delay,
    input  logic                   is_master,
    input  logic                   counter_trigger,
    input  logic                   ext_trigger,
    input  logic                   sata_trigger,
    input  logic                   watchdog,
    input  logic                   instant_reset,
    input  logic [NUM_CH-1:0]      ramp_enable,
    input  logic [NUM_CH-1:0]      ramp_done,
    output logic                   adc_aresetn,
    output logic [NUM_CH-1:0]      dac_aresetn,
    output logic [NUM_CH-1:0]      start_ramp_down,
    output logic                   keep_alive_aresetn,
    output logic                   alive_signal,
    output logic                   reset_ack,
    output logic                   master_trigger,
    output logic                   sata_out,
    output logic [31:0]            reset_sts
);

    localparam int RAMP_W       = $clog2(RAMP_TIMEOUT_CYCLES + 1);
    localparam int ALIVE_PERIOD = ALIVE_LOW_CYCLES + ALIVE_HIGH_CYCLES;
    localparam int ALIVE_W      = $clog2(ALIVE_PERIOD + 1);

    // RAMP lasts exactly RAMP_TIMEOUT_CYCLES cycles when it times out.
    localparam logic [RAMP_W-1:0]  RAMP_LOAD  = RAMP_W'(RAMP_TIMEOUT_CYCLES - 1);
    localparam logic [ALIVE_W-1:0] ALIVE_LAST = ALIVE_W'(ALIVE_PERIOD - 1);
    localparam logic [ALIVE_W-1:0] ALIVE_LOW  = ALIVE_W'(ALIVE_LOW_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RAMP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t state, state_n;

    // -----------------------------------------------------------------------
    // Input synchronizers. counter_trigger is already in this clock domain
    // but is delayed through the same two stages so every trigger source
    // reaches trig with identical latency.
    // Bit order: {counter, instant, watchdog, sata, ext}
    // -----------------------------------------------------------------------
    logic [4:0] sync_raw, sync_a, sync_b;
    logic       ext_s, sata_s, wd_s, inst_s, ctr_s;
    logic       trig, trig_n;

    assign sync_raw = {counter_trigger, instant_reset, watchdog, sata_trigger, ext_trigger};
    assign ext_s    = sync_b[0];
    assign sata_s   = sync_b[1];
    assign wd_s     = sync_b[2];
    assign inst_s   = sync_b[3];
    assign ctr_s    = sync_b[4];

    assign trig_n = cfg[4] ? ext_s : ((cfg[5] & ctr_s) | (~is_master & sata_s));

    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            sync_a <= '0;
            sync_b <= '0;
            trig   <= 1'b0;
        end else begin
            sync_a <= sync_raw;
            sync_b <= sync_a;
            trig   <= trig_n;
        end
    end

    // -----------------------------------------------------------------------
    // Fault sources
    // -----------------------------------------------------------------------
    logic wd_fault, wd_sticky;
    logic inst_fault, fault;
    logic any_ramp, ramp_clear;
    logic unused_wd;

    assign inst_fault = inst_s & cfg[3];
    assign fault      = inst_fault | wd_fault;
    assign any_ramp   = |ramp_enable;
    assign ramp_clear = &(ramp_done | ~ramp_enable);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic [ADC_DELAY_W-1:0] adc_cnt;
    logic [RAMP_W-1:0]      ramp_cnt;
    logic                   adc_load, ramp_load, ramp_to, fault_set, clear_sticky;

    always_comb begin
        state_n      = state;
        adc_load     = 1'b0;
        ramp_load    = 1'b0;
        ramp_to      = 1'b0;
        fault_set    = 1'b0;
        clear_sticky = 1'b0;
        if (!cfg[0]) begin
            // Continuous mode abandons any sequence without ramping.
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state_n      = ST_RUN;
                        adc_load     = 1'b1;
                        clear_sticky = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Fault is evaluated together with trigger loss so that a
                    // simultaneous fault is still recorded as the cause.
                    if (fault || !trig) begin
                        state_n   = any_ramp ? ST_RAMP : ST_HALT;
                        fault_set = fault;
                        ramp_load = 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (ramp_clear) begin
                        state_n = ST_HALT;
                    end else if (ramp_cnt == '0) begin
                        state_n = ST_HALT;
                        ramp_to = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (!trig) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State register, timers and sticky flags
    // -----------------------------------------------------------------------
    logic fault_lat, inst_sticky, rto_sticky;

    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            state       <= ST_IDLE;
            adc_cnt     <= '0;
            ramp_cnt    <= '0;
            fault_lat   <= 1'b0;
            inst_sticky <= 1'b0;
            rto_sticky  <= 1'b0;
        end else begin
            state <= state_n;

            if (adc_load)
                adc_cnt <= adc_delay;
            else if (state == ST_RUN && adc_cnt != '0)
                adc_cnt <= adc_cnt - ADC_DELAY_W'(1);

            if (ramp_load)
                ramp_cnt <= RAMP_LOAD;
            else if (state == ST_RAMP && ramp_cnt != '0)
                ramp_cnt <= ramp_cnt - RAMP_W'(1);

            if (state == ST_IDLE)
                fault_lat <= 1'b0;
            else if (fault_set)
                fault_lat <= 1'b1;

            if (clear_sticky) begin
                inst_sticky <= 1'b0;
                rto_sticky  <= 1'b0;
            end else begin
                if (fault_set && inst_fault) inst_sticky <= 1'b1;
                if (ramp_to)                 rto_sticky  <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Watchdog: down-counter reloaded on every synchronized edge and whenever
    // supervision is inactive, so it restarts on RUN entry.
    // -----------------------------------------------------------------------
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int              WD_W    = $clog2(WD_TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WD_TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_prev, wd_edge, wd_active;

    assign wd_edge   = wd_s ^ wd_prev;
    assign wd_active = (state == ST_RUN) && cfg[1];
    assign wd_fault  = wd_active && (wd_cnt == '0);
    assign unused_wd = 1'b0;

    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            wd_prev   <= 1'b0;
            wd_cnt    <= '0;
            wd_sticky <= 1'b0;
        end else begin
            wd_prev <= wd_s;
            if (!wd_active || wd_edge)
                wd_cnt <= WD_LOAD;
            else if (wd_cnt != '0)
                wd_cnt <= wd_cnt - WD_W'(1);

            if (clear_sticky)
                wd_sticky <= 1'b0;
            else if (fault_set && wd_fault)
                wd_sticky <= 1'b1;
        end
    end
`else
    assign wd_fault  = 1'b0;
    assign wd_sticky = 1'b0;
    assign unused_wd = cfg[1];
`endif

    // -----------------------------------------------------------------------
    // Output decode (registered below)
    // -----------------------------------------------------------------------
    logic              adc_n;
    logic [NUM_CH-1:0] dac_n, srd_n;
    logic              ack_n;
    logic [7:0]        done_ext;
    logic [31:0]       sts_n;

    always_comb begin
        adc_n = 1'b0;
        dac_n = '0;
        srd_n = '0;
        if (!cfg[0]) begin
            adc_n = 1'b1;
            dac_n = '1;
        end else begin
            case (state)
                ST_RUN: begin
                    dac_n = '1;
                    adc_n = (adc_cnt == '0);
                end
                ST_RAMP: begin
                    // Non-ramping channels drop at once; ramping ones follow
                    // their own ramp_done.
                    dac_n = ramp_enable & ~ramp_done;
                    srd_n = ramp_enable;
                end
                default: ;
            endcase
        end
    end

    assign ack_n = fault_lat && (state == ST_RAMP || state == ST_HALT);

    always_comb begin
        done_ext             = '0;
        done_ext[NUM_CH-1:0] = ramp_done;
        sts_n                = '0;
        sts_n[1:0]           = state;
        sts_n[2]             = trig;
        sts_n[3]             = adc_aresetn;
        sts_n[4]             = wd_s;
        sts_n[5]             = inst_s;
        sts_n[6]             = wd_sticky;
        sts_n[7]             = inst_sticky;
        sts_n[9]             = rto_sticky;
        sts_n[23:16]         = done_ext;
    end

    // -----------------------------------------------------------------------
    // Heartbeat: low for the first ALIVE_LOW_CYCLES of each period.
    // -----------------------------------------------------------------------
    logic [ALIVE_W-1:0] alive_cnt;

    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            alive_cnt    <= '0;
            alive_signal <= 1'b0;
        end else begin
            alive_cnt    <= (alive_cnt == ALIVE_LAST) ? '0 : alive_cnt + ALIVE_W'(1);
            alive_signal <= (alive_cnt >= ALIVE_LOW);
        end
    end

    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            adc_aresetn        <= 1'b0;
            dac_aresetn        <= '0;
            start_ramp_down    <= '0;
            reset_ack          <= 1'b0;
            reset_sts          <= '0;
            keep_alive_aresetn <= 1'b0;
            master_trigger     <= 1'b0;
            sata_out           <= 1'b0;
        end else begin
            adc_aresetn        <= adc_n;
            dac_aresetn        <= dac_n;
            start_ramp_down    <= srd_n;
            reset_ack          <= ack_n;
            reset_sts          <= sts_n;
            keep_alive_aresetn <= cfg[6];
            master_trigger     <= cfg[5] & counter_trigger;
            sata_out           <= trig & cfg[2];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{cfg[7], unused_wd};

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int NUM_CH     = 2;
    localparam int ALIVE_LOW  = 8;
    localparam int ALIVE_HIGH = 2;
    localparam int ALIVE_PER  = ALIVE_LOW + ALIVE_HIGH;
    localparam int WD_TO      = 100;
    localparam int RAMP_TO    = 500;
    localparam int ADW        = 16;
    // Pin to registered reset output: 2 sync + trig reg + state + output.
    localparam int LAT        = 5;
    localparam logic [7:0] KA = 8'h40;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        cfg = 8'h00;
    logic [ADW-1:0]    adc_delay = '0;
    logic              is_master = 1'b0;
    logic              counter_trigger = 1'b0;
    logic              ext_trigger = 1'b0;
    logic              sata_trigger = 1'b0;
    logic              watchdog = 1'b0;
    logic              instant_reset = 1'b0;
    logic [NUM_CH-1:0] ramp_enable = '0;
    logic [NUM_CH-1:0] ramp_done = '0;
    logic              adc;
    logic [NUM_CH-1:0] dac, srd;
    logic              ka, alive, ack, mtrig, sata_out;
    logic [31:0]       sts;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_CH(NUM_CH), .ALIVE_LOW_CYCLES(ALIVE_LOW), .ALIVE_HIGH_CYCLES(ALIVE_HIGH),
        .WD_TIMEOUT_CYCLES(WD_TO), .RAMP_TIMEOUT_CYCLES(RAMP_TO), .ADC_DELAY_W(ADW)
    ) dut (
        .clk(clk), .peripheral_areset(rst), .cfg(cfg), .adc_delay(adc_delay),
        .is_master(is_master), .counter_trigger(counter_trigger),
        .ext_trigger(ext_trigger), .sata_trigger(sata_trigger), .watchdog(watchdog),
        .instant_reset(instant_reset), .ramp_enable(ramp_enable), .ramp_done(ramp_done),
        .adc_aresetn(adc), .dac_aresetn(dac), .start_ramp_down(srd),
        .keep_alive_aresetn(ka), .alive_signal(alive), .reset_ack(ack),
        .master_trigger(mtrig), .sata_out(sata_out), .reset_sts(sts)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dac(input logic [NUM_CH-1:0] exp, input int limit, output int n);
        n = 0;
        while (dac !== exp && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({adc, dac, srd, ka, alive, ack, mtrig, sata_out});
    endfunction

    initial begin
        int d, hold, n, hi, per;
        bit use_sata, prop, found, prev;

        // ---------------- reset ----------------
        #1 rst = 1'b1;
        #1;
        chk("rst_outs_async", all_outs(), 0);
        chk("rst_sts_async", sts, 0);
        cfg = KA | 8'h11;
        ext_trigger = 1'b1;
        tick(3);
        chk("rst_outs_held", all_outs(), 0);
        chk("rst_sts_held", sts, 0);
        ext_trigger = 1'b0;
        cfg = 8'h00;
        @(negedge clk) rst = 1'b0;
        tick(3);

        // ---------------- continuous mode / registered passthroughs ----------------
        chk("cont_dac", 32'(dac), 3);
        chk("cont_adc", 32'(adc), 1);
        chk("cont_srd", 32'(srd), 0);
        chk("ka_off", 32'(ka), 0);
        cfg = KA | 8'h20;
        counter_trigger = 1'b1;
        tick(1);
        chk("mtrig_on", 32'(mtrig), 1);
        chk("ka_on", 32'(ka), 1);
        counter_trigger = 1'b0;
        tick(1);
        chk("mtrig_off", 32'(mtrig), 0);

        // ---------------- basic trigger sequences, random delay/source ----------------
        for (int i = 0; i < 4; i++) begin
            d        = (i == 0) ? 0 : int'($urandom_range(1, 30));
            use_sata = 1'($urandom_range(0, 1));
            prop     = 1'($urandom_range(0, 1));
            hold     = int'($urandom_range(2, 20));
            adc_delay = ADW'(d);
            is_master = 1'b0;
            cfg = KA | (use_sata ? 8'h01 : 8'h11) | (prop ? 8'h04 : 8'h00);
            tick(4);
            chk("idle_dac", 32'(dac), 0);
            chk("idle_adc", 32'(adc), 0);
            if (use_sata) sata_trigger = 1'b1; else ext_trigger = 1'b1;
            tick(LAT - 1);
            chk("run_dac_early", 32'(dac), 0);
            tick(1);
            chk("run_dac", 32'(dac), 3);
            chk("sata_out", 32'(sata_out), 32'(prop));
            if (d == 0) begin
                chk("adc_nodelay", 32'(adc), 1);
            end else begin
                tick(d - 1);
                chk("adc_early", 32'(adc), 0);
                tick(1);
                chk("adc_release", 32'(adc), 1);
            end
            tick(hold);
            chk("sts_run", sts[3:0], 4'b1101);
            sata_trigger = 1'b0;
            ext_trigger  = 1'b0;
            tick(LAT - 1);
            chk("fall_dac_hold", 32'(dac), 3);
            tick(1);
            chk("fall_dac", 32'(dac), 0);
            chk("fall_adc", 32'(adc), 0);
            tick(5);
            chk("fall_idle", sts[2:0], 0);
            chk("fall_ack", 32'(ack), 0);
        end

        // ---------------- continuous mode forced mid-RAMP ----------------
        adc_delay = 3;
        ramp_enable = 2'b11;
        cfg = KA | 8'h11;
        ext_trigger = 1'b1;
        tick(LAT + 4);
        ext_trigger = 1'b0;
        tick(LAT + 3);
        chk("cm_in_ramp", 32'(srd), 3);
        cfg = KA | 8'h10;
        tick(1);
        chk("cm_srd", 32'(srd), 0);
        chk("cm_dac", 32'(dac), 3);
        chk("cm_adc", 32'(adc), 1);
        tick(3);
        chk("cm_state", sts[1:0], 0);
        ramp_enable = 2'b00;
        cfg = KA | 8'h11;
        tick(4);

        // ---------------- watchdog ----------------
`ifdef RESET_SEQ_WATCHDOG_EN
        cfg = KA | 8'h13;
        adc_delay = 0;
        ext_trigger = 1'b1;
        tick(LAT);
        chk("wd_run", 32'(dac), 3);
        for (int k = 0; k < 6; k++) begin
            watchdog = ~watchdog;
            tick(50);
        end
        chk("wd_alive_dac", 32'(dac), 3);
        chk("wd_alive_state", sts[1:0], 1);
        watchdog = ~watchdog;
        wait_dac(2'b00, 200, n);
        chk("wd_latency", n, WD_TO + LAT);
        chk("wd_ack", 32'(ack), 1);
        tick(2);
        chk("wd_sticky", sts[7:6], 2'b01);
        chk("wd_halt", sts[1:0], 3);
        ext_trigger = 1'b0;
        tick(8);
        chk("wd_ack_clr", 32'(ack), 0);
        chk("wd_idle", sts[1:0], 0);
`else
        cfg = KA | 8'h13;
        adc_delay = 0;
        ext_trigger = 1'b1;
        tick(LAT + 300);
        chk("nowd_run", 32'(dac), 3);
        chk("nowd_sticky", 32'(sts[6]), 0);
        ext_trigger = 1'b0;
        tick(10);
`endif

        // ---------------- instant reset with ramp on ch0 ----------------
        cfg = KA | 8'h19;
        adc_delay = 0;
        ramp_enable = 2'b01;
        ext_trigger = 1'b1;
        tick(LAT);
        chk("ir_run", 32'(dac), 3);
        tick(int'($urandom_range(3, 20)));
        instant_reset = 1'b1;
        tick(3);
        chk("ir_srd_early", 32'(srd), 0);
        tick(1);
        chk("ir_srd", 32'(srd), 1);
        chk("ir_dac", 32'(dac), 1);
        chk("ir_ack", 32'(ack), 1);
        instant_reset = 1'b0;
        tick(200);
        chk("ir_wait_dac", 32'(dac), 1);
        ramp_done = 2'b01;
        tick(1);
        chk("ir_done_dac", 32'(dac), 0);
        tick(1);
        chk("ir_done_srd", 32'(srd), 0);
        tick(2);
        chk("ir_halt", sts[1:0], 3);
        chk("ir_sticky", 32'({sts[9], sts[7]}), 1);
        chk("ir_done_sts", sts[23:16], 1);
        ramp_done = 2'b00;
        ext_trigger = 1'b0;
        tick(10);
        chk("ir_ack_clr", 32'(ack), 0);

        // ---------------- ramp timeout ----------------
        cfg = KA | 8'h11;
        ramp_enable = 2'b11;
        ext_trigger = 1'b1;
        tick(LAT + 3);
        ext_trigger = 1'b0;
        wait_dac(2'b00, 700, n);
        chk("rto_latency", n, RAMP_TO + LAT);
        chk("rto_ack", 32'(ack), 0);
        tick(2);
        chk("rto_sticky", 32'(sts[9]), 1);
        chk("rto_idle", sts[1:0], 0);
        ramp_enable = 2'b00;
        ext_trigger = 1'b1;
        tick(LAT + 2);
        chk("rto_rearm_state", sts[1:0], 1);
        chk("rto_sticky_clr", 32'(sts[9]), 0);
        ext_trigger = 1'b0;
        tick(10);

        // ---------------- HALT holds while trigger high ----------------
        cfg = KA | 8'h19;
        ext_trigger = 1'b1;
        tick(LAT + 2);
        instant_reset = 1'b1;
        tick(3);
        instant_reset = 1'b0;
        tick(30);
        chk("hh_state", sts[1:0], 3);
        chk("hh_dac", 32'(dac), 0);
        chk("hh_ack", 32'(ack), 1);
        chk("hh_sticky", 32'(sts[7]), 1);
        ext_trigger = 1'b0;
        tick(8);
        chk("hh_idle", sts[1:0], 0);
        chk("hh_ack_clr", 32'(ack), 0);
        ext_trigger = 1'b1;
        tick(LAT + 2);
        chk("hh_rearm", sts[1:0], 1);
        chk("hh_sticky_clr", 32'(sts[7]), 0);
        chk("hh_rearm_dac", 32'(dac), 3);
        ext_trigger = 1'b0;
        tick(10);

        // ---------------- heartbeat ----------------
        found = 1'b0;
        prev  = alive;
        for (int c = 0; c < 40 && !found; c++) begin
            tick(1);
            if (alive && !prev) found = 1'b1;
            prev = alive;
        end
        chk("alive_rise", 32'(found), 1);
        hi = 0;
        while (alive && hi < 40) begin tick(1); hi++; end
        per = hi;
        while (!alive && per < 40) begin tick(1); per++; end
        chk("alive_high", hi, ALIVE_HIGH);
        chk("alive_period", per, ALIVE_PER);
        for (int k = 0; k < 25; k++) begin
            chk("alive_pattern", 32'(alive), 32'((k % ALIVE_PER) < ALIVE_HIGH));
            tick(1);
        end

        // ---------------- async reset mid-RAMP while heartbeat high ----------------
        cfg = KA | 8'h11;
        ramp_enable = 2'b11;
        ext_trigger = 1'b1;
        tick(LAT + 2);
        ext_trigger = 1'b0;
        tick(20);
        chk("ar_in_ramp", 32'(srd), 3);
        n = 0;
        while (!alive && n < 12) begin tick(1); n++; end
        chk("ar_alive_high", 32'(alive), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_outs", all_outs(), 0);
        chk("ar_sts", sts, 0);
        @(negedge clk) rst = 1'b0;
        ramp_enable = 2'b00;
        tick(3);
        chk("ar_after_idle", 32'(dac), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
